// File: rtl/ps2_message_builder_if.sv
// Handshake and payload signals between the PS/2 message builder and its host.
// The slave modport is the builder's view; master is the driver/consumer side.
interface ps2_message_builder_if #(
  parameter int unsigned MSG_BYTES = 16
);
  localparam int unsigned CNT_W = $clog2(MSG_BYTES + 1);

  logic                   scan_valid;
  logic [7:0]             scan_code;
  logic                   send;
  logic                   done;
  logic [MSG_BYTES*8-1:0] message_out;
  logic                   data_ready;
  logic [CNT_W-1:0]       char_count;
  logic                   char_valid;
  logic [7:0]             char_ascii;

  modport master (
    output scan_valid, scan_code, send, done,
    input  message_out, data_ready, char_count, char_valid, char_ascii
  );

  modport slave (
    input  scan_valid, scan_code, send, done,
    output message_out, data_ready, char_count, char_valid, char_ascii
  );
endinterface

// File: rtl/ps2_message_builder.sv
// Turns PS/2 set-2 scan codes into a fixed-length ASCII message buffer, commits it
// on enter/send and holds it frozen until the downstream link reports done.
module ps2_message_builder #(
  parameter logic [7:0]  PAD_CHAR  = 8'h20,
  parameter int unsigned MSG_BYTES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  ps2_message_builder_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(MSG_BYTES + 1);
  localparam int unsigned IDX_W = $clog2(MSG_BYTES);

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] ASCII_DEL  = 8'h7F;

  typedef enum logic [1:0] {D_MAKE, D_BREAK, D_EXT, D_EXT_BREAK} dec_state_e;
  typedef enum logic       {BUILD, PENDING}                      ctl_state_e;
  typedef enum logic [1:0] {K_NONE, K_PRINT, K_BS, K_ENTER}      key_kind_e;

  dec_state_e                   dec_state_q, dec_state_d;
  ctl_state_e                   ctl_state_q, ctl_state_d;
  logic [MSG_BYTES-1:0][7:0]    msg_q, msg_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         ready_q, ready_d;
  logic                         char_valid_q, char_valid_d;
  logic [7:0]                   char_ascii_q, char_ascii_d;

  key_kind_e                    key_kind_c;
  logic [7:0]                   key_ascii_c;
  logic                         make_ev_c;
  logic                         commit_c;
  logic [IDX_W-1:0]             wr_idx_c;
  logic [IDX_W-1:0]             bs_idx_c;

  // Set-2 make-code map
  always_comb begin
    key_kind_c  = K_PRINT;
    key_ascii_c = 8'h00;
    case (bus.scan_code)
      8'h1C: key_ascii_c = 8'h61;
      8'h32: key_ascii_c = 8'h62;
      8'h21: key_ascii_c = 8'h63;
      8'h23: key_ascii_c = 8'h64;
      8'h24: key_ascii_c = 8'h65;
      8'h2B: key_ascii_c = 8'h66;
      8'h34: key_ascii_c = 8'h67;
      8'h33: key_ascii_c = 8'h68;
      8'h43: key_ascii_c = 8'h69;
      8'h3B: key_ascii_c = 8'h6A;
      8'h42: key_ascii_c = 8'h6B;
      8'h4B: key_ascii_c = 8'h6C;
      8'h3A: key_ascii_c = 8'h6D;
      8'h31: key_ascii_c = 8'h6E;
      8'h44: key_ascii_c = 8'h6F;
      8'h4D: key_ascii_c = 8'h70;
      8'h15: key_ascii_c = 8'h71;
      8'h2D: key_ascii_c = 8'h72;
      8'h1B: key_ascii_c = 8'h73;
      8'h2C: key_ascii_c = 8'h74;
      8'h3C: key_ascii_c = 8'h75;
      8'h2A: key_ascii_c = 8'h76;
      8'h1D: key_ascii_c = 8'h77;
      8'h22: key_ascii_c = 8'h78;
      8'h35: key_ascii_c = 8'h79;
      8'h1A: key_ascii_c = 8'h7A;
      8'h29: key_ascii_c = 8'h20;
      8'h66: key_kind_c  = K_BS;
      8'h5A: key_kind_c  = K_ENTER;
      default: key_kind_c = K_NONE;
    endcase
  end

  // Byte i of the message sits at packed index MSG_BYTES-1-i (byte 0 in the MSBs)
  assign wr_idx_c = IDX_W'(MSG_BYTES - 1) - count_q[IDX_W-1:0];
  assign bs_idx_c = wr_idx_c + IDX_W'(1);

  // Decoder and control next-state
  always_comb begin
    dec_state_d  = dec_state_q;
    ctl_state_d  = ctl_state_q;
    msg_d        = msg_q;
    count_d      = count_q;
    ready_d      = ready_q;
    char_valid_d = 1'b0;
    char_ascii_d = char_ascii_q;
    make_ev_c    = 1'b0;
    commit_c     = 1'b0;

    if (bus.scan_valid) begin
      case (dec_state_q)
        D_MAKE: begin
          if (bus.scan_code == CODE_BREAK)    dec_state_d = D_BREAK;
          else if (bus.scan_code == CODE_EXT) dec_state_d = D_EXT;
          else                                make_ev_c   = 1'b1;
        end
        D_BREAK:     dec_state_d = D_MAKE;
        D_EXT:       dec_state_d = (bus.scan_code == CODE_BREAK) ? D_EXT_BREAK : D_MAKE;
        D_EXT_BREAK: dec_state_d = D_MAKE;
        default:     dec_state_d = D_MAKE;
      endcase
    end

    case (ctl_state_q)
      BUILD: begin
        if (make_ev_c && key_kind_c == K_PRINT && count_q < CNT_W'(MSG_BYTES)) begin
          msg_d[wr_idx_c] = key_ascii_c;
          count_d         = count_q + CNT_W'(1);
          char_valid_d    = 1'b1;
          char_ascii_d    = key_ascii_c;
        end else if (make_ev_c && key_kind_c == K_BS && count_q != '0) begin
          msg_d[bs_idx_c] = PAD_CHAR;
          count_d         = count_q - CNT_W'(1);
          char_valid_d    = 1'b1;
          char_ascii_d    = ASCII_DEL;
        end
        // Commit sees the count after this cycle's character
        commit_c = bus.send || (make_ev_c && key_kind_c == K_ENTER);
        if (commit_c && count_d != '0) begin
          ctl_state_d = PENDING;
          ready_d     = 1'b1;
        end
      end
      PENDING: begin
        if (bus.done) begin
          msg_d       = {MSG_BYTES{PAD_CHAR}};
          count_d     = '0;
          ready_d     = 1'b0;
          ctl_state_d = BUILD;
        end
      end
      default: ctl_state_d = BUILD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dec_state_q  <= D_MAKE;
      ctl_state_q  <= BUILD;
      msg_q        <= {MSG_BYTES{PAD_CHAR}};
      count_q      <= '0;
      ready_q      <= 1'b0;
      char_valid_q <= 1'b0;
      char_ascii_q <= 8'h00;
    end else begin
      dec_state_q  <= dec_state_d;
      ctl_state_q  <= ctl_state_d;
      msg_q        <= msg_d;
      count_q      <= count_d;
      ready_q      <= ready_d;
      char_valid_q <= char_valid_d;
      char_ascii_q <= char_ascii_d;
    end
  end

  assign bus.message_out = msg_q;
  assign bus.char_count  = count_q;
  assign bus.data_ready  = ready_q;
  assign bus.char_valid  = char_valid_q;
  assign bus.char_ascii  = char_ascii_q;

endmodule

// File: tb/tb_ps2_message_builder.sv
// Directed and random stimulus for ps2_message_builder, checked every cycle against
// a queue-based model of the typed message.
module tb_ps2_message_builder;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ps2_message_builder_if #(.MSG_BYTES(16)) bus ();

  ps2_message_builder #(.PAD_CHAR(8'h20), .MSG_BYTES(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] keymap [256];
  logic [7:0] m_msg [$];
  bit         m_ready;
  bit         m_cv;
  logic [7:0] m_ascii;
  int         m_swallow;
  bit         m_ext;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_msg();
    logic [127:0] v;
    for (int i = 0; i < 16; i++)
      v[127-8*i -: 8] = (i < m_msg.size()) ? m_msg[i] : 8'h20;
    return v;
  endfunction

  task automatic model(input bit sv, input logic [7:0] code, input bit snd,
                       input bit dn, input bit rst);
    bit is_make;
    bit commit;
    is_make = 1'b0;
    commit  = 1'b0;
    m_cv    = 1'b0;
    if (rst) begin
      m_msg.delete();
      m_ready   = 1'b0;
      m_ascii   = 8'h00;
      m_swallow = 0;
      m_ext     = 1'b0;
      return;
    end
    if (sv) begin
      if (m_swallow != 0) begin
        if (m_ext && code == 8'hF0) m_ext = 1'b0;
        else begin m_swallow = 0; m_ext = 1'b0; end
      end else if (code == 8'hF0) m_swallow = 1;
      else if (code == 8'hE0) begin m_swallow = 1; m_ext = 1'b1; end
      else is_make = 1'b1;
    end
    if (!m_ready) begin
      if (is_make && keymap[code] != 8'h00) begin
        if (m_msg.size() < 16) begin
          m_msg.push_back(keymap[code]);
          m_cv = 1'b1; m_ascii = keymap[code];
        end
      end else if (is_make && code == 8'h66) begin
        if (m_msg.size() > 0) begin
          void'(m_msg.pop_back());
          m_cv = 1'b1; m_ascii = 8'h7F;
        end
      end else if (is_make && code == 8'h5A) commit = 1'b1;
      if ((commit || snd) && m_msg.size() > 0) m_ready = 1'b1;
    end else if (dn) begin
      m_msg.delete();
      m_ready = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".message_out"}, bus.message_out, exp_msg());
    chk({tag, ".char_count"}, 128'(bus.char_count), 128'(m_msg.size()));
    chk({tag, ".data_ready"}, 128'(bus.data_ready), 128'(m_ready));
    chk({tag, ".char_valid"}, 128'(bus.char_valid), 128'(m_cv));
    chk({tag, ".char_ascii"}, 128'(bus.char_ascii), 128'(m_ascii));
  endtask

  task automatic cyc(input string tag, input bit sv, input logic [7:0] code,
                     input bit snd, input bit dn, input bit rst);
    reset          = rst;
    bus.scan_valid = sv;
    bus.scan_code  = code;
    bus.send       = snd;
    bus.done       = dn;
    @(posedge clock);
    model(sv, code, snd, dn, rst);
    #1;
    reset = 1'b0; bus.scan_valid = 1'b0; bus.send = 1'b0; bus.done = 1'b0;
    check_all(tag);
  endtask

  task automatic mk(input string tag, input logic [7:0] code);
    cyc(tag, 1'b1, code, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tap(input string tag, input logic [7:0] code);
    mk(tag, code); mk(tag, 8'hF0); mk(tag, code);
  endtask

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] pool [12] = '{8'h1C, 8'h32, 8'h33, 8'h43, 8'h29, 8'h66, 8'h66, 8'h5A,
    8'hF0, 8'hE0, 8'h1A, 8'h00};

  initial begin
    for (int i = 0; i < 256; i++) keymap[i] = 8'h00;
    for (int i = 0; i < 26; i++) keymap[letter_codes[i]] = 8'(8'h61 + i);
    keymap[8'h29] = 8'h20;
    bus.scan_valid = 1'b0; bus.scan_code = 8'h00; bus.send = 1'b0; bus.done = 1'b0;

    cyc("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // "hi" with break codes
    tap("hi", 8'h33); tap("hi", 8'h43);
    chk("hi.prefix", bus.message_out[127:112], 128'h6869);

    // 17 a's: the last is dropped
    cyc("fill.rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) tap("fill", 8'h1C);
    chk("fill.count16", 128'(bus.char_count), 128'd16);

    // Backspaces, including one on an empty buffer
    cyc("bs.rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tap("bs", 8'h1C); tap("bs", 8'h32);
    for (int i = 0; i < 3; i++) mk("bs", 8'h66);
    chk("bs.byte0", bus.message_out[127:120], 128'h20);

    // Send, dropped key while pending, done
    tap("send", 8'h1C);
    cyc("send", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tap("send.pend", 8'h32);
    cyc("send.pend", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc("send.done", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc("send.idle", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Extended prefixes swallow the following byte(s)
    mk("ext", 8'hE0); mk("ext", 8'h1C); mk("ext", 8'hE0);
    mk("ext", 8'hF0); mk("ext", 8'h1C); mk("ext", 8'h1C);

    // Character and send in one cycle, enter with empty buffer
    cyc("mix.rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    mk("mix.enter0", 8'h5A);
    cyc("mix.send", 1'b1, 8'h1C, 1'b1, 1'b0, 1'b0);
    cyc("mix.done", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tap("mix", 8'h32); mk("mix.enter", 8'h5A);

    // Reset while pending and while mid-break
    cyc("rst.pend", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    mk("rst.a", 8'h1C);
    mk("rst.brk", 8'hF0);
    cyc("rst.brk", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    mk("rst.a2", 8'h1C);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] code;
      code = pool[$urandom_range(11)];
      if (code == 8'h00) code = 8'($urandom);
      cyc("rand", ($urandom_range(99) < 60), code, ($urandom_range(99) < 5),
          ($urandom_range(99) < 15), ($urandom_range(999) < 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
